boot_load_ctl: RTL and testbench

//  Boot/program-load sequencer for the RISC CPU memory bus. It holds the CPU core in reset,

---
 rtl/boot_load_ctl_pkg.sv | 25 ++
 rtl/boot_load_ctl_if.sv | 29 ++
 rtl/boot_load_ctl_cyc_timer.sv | 30 +++
 rtl/boot_load_ctl.sv | 178 +++++++++++++++++
 tb/tb_boot_load_ctl.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_load_ctl_pkg.sv
// Shared definitions for the boot/program-load sequencer: bus width defaults,
// timing defaults and the sequencer state encoding.
// Widths match the RISC CPU memory bus.
package boot_load_ctl_pkg;

  localparam int ADDR_W_DEF    = 13;
  localparam int DATA_W_DEF    = 8;
  localparam int WR_CYCLES_DEF = 2;
  localparam int RST_HOLD_DEF  = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_SETUP     = 3'd2,
    S_WRITE     = 3'd3,
    S_HOLD      = 3'd4,
    S_RELEASE   = 3'd5
  } state_t;

  // Larger of two phase lengths; sizes the shared phase timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/boot_load_ctl_if.sv
// Loader byte stream plus RAM-side write bus owned by the load sequencer.
// master = sequencer side, slave = loader source / RAM side.
// in_valid & in_ready is a byte transfer; mem_* are stable through each write.
interface boot_load_ctl_if
  import boot_load_ctl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_oe;
  logic              mem_wr;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_data, mem_oe, mem_wr
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_data, mem_oe, mem_wr
  );

endinterface

// File: rtl/boot_load_ctl_cyc_timer.sv
// Loadable down-counter with a zero flag, timing the WRITE and RELEASE phases.
// Latency: load/decrement visible the cycle after the request.
// No backpressure; decrement saturates at zero.
module boot_load_ctl_cyc_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over decrement; counting stops at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/boot_load_ctl.sv
// Boot loader: holds the CPU in reset, streams loader bytes into RAM, then releases the CPU.
// Latency: one byte per WR_CYCLES+3 cycles; done RST_HOLD+1 cycles after the last HOLD.
// Backpressure: in_ready only in WAIT_DATA; start outside IDLE is ignored.
module boot_load_ctl
  import boot_load_ctl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF,
  parameter int RST_HOLD  = RST_HOLD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  boot_load_ctl_if.master   bus,
  output logic              cpu_rst,
  output logic              bus_grant_cpu,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TMR_W = $clog2(max_int(WR_CYCLES, RST_HOLD) + 1);
  // A full-memory load (2^ADDR_W bytes) is the largest legal request.
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;
  logic [ADDR_W:0]   len_q, len_nxt;
  logic [ADDR_W:0]   idx_q, idx_nxt;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              oe_q, oe_nxt;
  logic              cpu_rst_q, cpu_rst_nxt;
  logic              done_q, done_nxt;
  logic              err_q, err_nxt;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]  tmr_val;

  assign idx_inc = idx_q + IDX_ONE;

  boot_load_ctl_cyc_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State and bus registers; reset parks the CPU in reset with the bus idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      oe_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      base_q    <= base_nxt;
      len_q     <= len_nxt;
      idx_q     <= idx_nxt;
      addr_q    <= addr_nxt;
      data_q    <= data_nxt;
      oe_q      <= oe_nxt;
      cpu_rst_q <= cpu_rst_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  // Next-state and register updates for the load sequence.
  always_comb begin
    state_nxt   = state_q;
    base_nxt    = base_q;
    len_nxt     = len_q;
    idx_nxt     = idx_q;
    addr_nxt    = addr_q;
    data_nxt    = data_q;
    oe_nxt      = oe_q;
    cpu_rst_nxt = cpu_rst_q;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length > LEN_MAX) begin
            err_nxt = 1'b1;
          end else begin
            // A running CPU is re-reset and the bus reclaimed.
            base_nxt    = base_addr;
            len_nxt     = length;
            idx_nxt     = '0;
            cpu_rst_nxt = 1'b1;
            if (length == '0) begin
              state_nxt = S_RELEASE;
              tmr_load  = 1'b1;
              tmr_val   = TMR_W'(RST_HOLD - 1);
            end else begin
              state_nxt = S_WAIT_DATA;
            end
          end
        end
      end
      S_WAIT_DATA: begin
        if (bus.in_valid) begin
          data_nxt  = bus.in_data;
          // Address wraps modulo 2^ADDR_W by truncation.
          addr_nxt  = base_q + idx_q[ADDR_W-1:0];
          oe_nxt    = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(WR_CYCLES - 1);
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (tmr_zero) begin
          state_nxt = S_HOLD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_HOLD: begin
        idx_nxt = idx_inc;
        if (idx_inc == len_q) begin
          state_nxt = S_RELEASE;
          oe_nxt    = 1'b0;
          addr_nxt  = '0;
          data_nxt  = '0;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(RST_HOLD - 1);
        end else begin
          state_nxt = S_WAIT_DATA;
        end
      end
      S_RELEASE: begin
        if (tmr_zero) begin
          state_nxt   = S_IDLE;
          cpu_rst_nxt = 1'b0;
          done_nxt    = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == S_WAIT_DATA);
  assign bus.mem_wr    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = data_q;
  assign bus.mem_oe    = oe_q;
  assign cpu_rst       = cpu_rst_q;
  assign bus_grant_cpu = !cpu_rst_q && (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_boot_load_ctl.sv
// Directed bench for boot_load_ctl: reset hold, streaming loads, wrap, zero/oversize
// lengths, ignored restarts with gappy input, and reset during a write.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_boot_load_ctl;
  import boot_load_ctl_pkg::*;

  localparam int AW   = 13;
  localparam int DW   = 8;
  localparam int WRC  = 2;
  localparam int RSTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          cpu_rst, bus_grant_cpu, busy, done, err;

  boot_load_ctl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  boot_load_ctl #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WRC), .RST_HOLD(RSTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .bus           (bus),
    .cpu_rst       (cpu_rst),
    .bus_grant_cpu (bus_grant_cpu),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bus monitor: logs each write strobe, strobe widths, pulses and invariant breaks.
  int            cyc = 0, wr_n = 0, bad_strobe = 0, viol_n = 0, done_n = 0, err_n = 0;
  int            run_len = 0, last_fall = 0, done_cyc = 0;
  logic          wr_prev = 1'b0;
  logic [AW-1:0] wr_addr [0:63];
  logic [DW-1:0] wr_data [0:63];
  int            wr_cyc  [0:63];
  logic [DW-1:0] src     [0:15];

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    wr_prev <= bus.mem_wr;
    if (bus.mem_wr && !wr_prev && wr_n < 64) begin
      wr_addr[wr_n] <= bus.mem_addr;
      wr_data[wr_n] <= bus.mem_data;
      wr_cyc[wr_n]  <= cyc;
      wr_n          <= wr_n + 1;
    end
    if (bus.mem_wr) begin
      run_len <= run_len + 1;
    end else if (wr_prev) begin
      if (run_len != WRC) bad_strobe <= bad_strobe + 1;
      run_len   <= 0;
      last_fall <= cyc;
    end
    if ((bus.in_ready && (bus.mem_wr || !busy)) ||
        (bus_grant_cpu && (bus.mem_oe || bus.mem_addr != '0 || bus.mem_data != '0)) ||
        (bus_grant_cpu !== (!cpu_rst && !busy)) ||
        (bus.mem_wr && !bus.mem_oe))
      viol_n <= viol_n + 1;
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (err) err_n <= err_n + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] l);
    @(negedge clk);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Feeds src[0..n-1]; pct is the per-cycle chance (percent) of presenting a byte.
  task automatic send_bytes(input int n, input int pct, input int budget);
    int i = 0;
    int k = 0;
    logic v;
    while (i < n && k < budget) begin
      v = (pct >= 100) ? 1'b1 : (int'($urandom_range(99, 0)) < pct);
      bus.in_valid = v;
      bus.in_data  = v ? src[i] : 8'hEE;
      if (v && bus.in_ready === 1'b1) i++;
      @(negedge clk);
      k++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic got);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    got = (done === 1'b1);
  endtask

  task automatic test_reset();
    int bad = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cpu_rst !== 1'b1 || bus_grant_cpu !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: cpu_rst=%b grant=%b busy=%b, required 1 0 0", cpu_rst, bus_grant_cpu, busy);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.mem_wr !== 1'b0 || bus.mem_oe !== 1'b0 ||
        bus.mem_addr !== '0 || bus.mem_data !== '0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: rdy=%b wr=%b oe=%b addr=%h data=%h done=%b err=%b, required all 0",
               bus.in_ready, bus.mem_wr, bus.mem_oe, bus.mem_addr, bus.mem_data, done, err);
    end
    reset = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (cpu_rst !== 1'b1 || bus_grant_cpu !== 1'b0 || busy !== 1'b0 ||
          bus.in_ready !== 1'b0 || bus.mem_wr !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_hold: %0d bad cycles of 100, required 0", bad);
    end
  endtask

  task automatic test_basic();
    int n0 = wr_n, b0 = bad_strobe, d0 = done_n;
    logic got;
    src[0] = 8'hA5; src[1] = 8'h3C; src[2] = 8'hFF;
    pulse_start(13'h0000, 14'd3);
    send_bytes(3, 100, 100);
    wait_done(60, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL basic_done: done not seen, required pulse"); end
    n_checks++;
    if (cpu_rst !== 1'b0 || bus_grant_cpu !== 1'b1 || bus.mem_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: cpu_rst=%b grant=%b oe=%b, required 0 1 0", cpu_rst, bus_grant_cpu, bus.mem_oe);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: done=%b, required 0", done); end
    @(negedge clk);
    n_checks++;
    if (wr_n - n0 != 3) begin n_fail++; $display("FAIL basic_count: %0d writes, required 3", wr_n - n0); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wr_addr[n0+i] !== AW'(i) || wr_data[n0+i] !== src[i]) begin
        n_fail++;
        $display("FAIL basic_write[%0d]: addr=%h data=%h, required %h %h", i, wr_addr[n0+i], wr_data[n0+i], AW'(i), src[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (wr_cyc[n0+i] - wr_cyc[n0+i-1] != 5) begin
        n_fail++;
        $display("FAIL basic_period[%0d]: %0d cycles, required 5", i, wr_cyc[n0+i] - wr_cyc[n0+i-1]);
      end
    end
    // Last HOLD, four RELEASE cycles, then the done cycle.
    n_checks++;
    if (done_cyc - last_fall != 5) begin
      n_fail++;
      $display("FAIL basic_done_lat: %0d cycles after HOLD, required 5", done_cyc - last_fall);
    end
    n_checks++;
    if (bad_strobe != b0 || done_n - d0 != 1) begin
      n_fail++;
      $display("FAIL basic_strobe: bad strobes=%0d dones=%0d, required 0 1", bad_strobe - b0, done_n - d0);
    end
  endtask

  task automatic test_wrap();
    int n0 = wr_n, e0 = err_n;
    logic got;
    logic [AW-1:0] exp_a [0:3];
    exp_a[0] = 13'h1FFE; exp_a[1] = 13'h1FFF; exp_a[2] = 13'h0000; exp_a[3] = 13'h0001;
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
    pulse_start(13'h1FFE, 14'd4);
    send_bytes(4, 100, 100);
    wait_done(60, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL wrap_done: done not seen, required pulse"); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_n - n0 != 4 || err_n != e0) begin
      n_fail++;
      $display("FAIL wrap_count: writes=%0d errs=%0d, required 4 0", wr_n - n0, err_n - e0);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wr_addr[n0+i] !== exp_a[i] || wr_data[n0+i] !== src[i]) begin
        n_fail++;
        $display("FAIL wrap_write[%0d]: addr=%h data=%h, required %h %h", i, wr_addr[n0+i], wr_data[n0+i], exp_a[i], src[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    int n0 = wr_n;
    int hi = 0;
    int k = 0;
    pulse_start(13'h0123, 14'd0);
    while (done !== 1'b1 && k < 50) begin
      if (cpu_rst === 1'b1) hi++;
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (done !== 1'b1 || hi != RSTH) begin
      n_fail++;
      $display("FAIL zero_len: done=%b cpu_rst high %0d cycles, required 1 and %0d", done, hi, RSTH);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_n != n0 || bus_grant_cpu !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_len_bus: writes=%0d grant=%b, required 0 1", wr_n - n0, bus_grant_cpu);
    end
    pulse_start(13'h0000, 14'h2001);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b0 || bus_grant_cpu !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize: err=%b busy=%b cpu_rst=%b grant=%b, required 1 0 0 1", err, busy, cpu_rst, bus_grant_cpu);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL oversize_width: err=%b, required 0", err); end
    pulse_start(13'h0000, 14'h2000);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1 || cpu_rst !== 1'b1 || bus_grant_cpu !== 1'b0) begin
      n_fail++;
      $display("FAIL full_len_accept: err=%b busy=%b cpu_rst=%b grant=%b, required 0 1 1 0", err, busy, cpu_rst, bus_grant_cpu);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n0 = wr_n, d0 = done_n, v0 = viol_n, b0 = bad_strobe;
    logic got;
    src[0] = 8'h01; src[1] = 8'h80; src[2] = 8'h7E; src[3] = 8'hC3; src[4] = 8'h00; src[5] = 8'h5A;
    pulse_start(13'h0100, 14'd6);
    fork
      send_bytes(6, 50, 600);
      begin
        repeat (7) @(negedge clk);
        pulse_start(13'h0500, 14'd2);
        repeat (9) @(negedge clk);
        pulse_start(13'h0700, 14'd0);
      end
    join
    wait_done(80, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL b2b_done: done not seen, required pulse"); end
    repeat (10) @(negedge clk);
    n_checks++;
    if (wr_n - n0 != 6 || done_n - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count: writes=%0d dones=%0d busy=%b, required 6 1 0", wr_n - n0, done_n - d0, busy);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (wr_addr[n0+i] !== AW'(13'h0100 + i) || wr_data[n0+i] !== src[i]) begin
        n_fail++;
        $display("FAIL b2b_write[%0d]: addr=%h data=%h, required %h %h", i, wr_addr[n0+i], wr_data[n0+i], AW'(13'h0100 + i), src[i]);
      end
    end
    n_checks++;
    if (viol_n != v0 || bad_strobe != b0) begin
      n_fail++;
      $display("FAIL b2b_protocol: violations=%0d bad strobes=%0d, required 0 0", viol_n - v0, bad_strobe - b0);
    end
  endtask

  task automatic test_reset_mid();
    int n0, b0;
    logic got;
    src[0] = 8'hD0; src[1] = 8'hD1; src[2] = 8'hD2; src[3] = 8'hD3; src[4] = 8'hD4;
    pulse_start(13'h0040, 14'd5);
    send_bytes(2, 100, 50);
    @(negedge clk);
    n_checks++;
    if (bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL mid_in_write: mem_wr=%b, required 1", bus.mem_wr); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_wr !== 1'b0 || cpu_rst !== 1'b1 || busy !== 1'b0 || bus_grant_cpu !== 1'b0 ||
        bus.in_ready !== 1'b0 || bus.mem_oe !== 1'b0 || bus.mem_addr !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: wr=%b cpu_rst=%b busy=%b grant=%b rdy=%b oe=%b addr=%h, required 0 1 0 0 0 0 0",
               bus.mem_wr, cpu_rst, busy, bus_grant_cpu, bus.in_ready, bus.mem_oe, bus.mem_addr);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n0 = wr_n;
    b0 = bad_strobe;
    pulse_start(13'h0040, 14'd5);
    send_bytes(5, 100, 100);
    wait_done(60, got);
    n_checks++;
    if (!got || bus_grant_cpu !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reload_done: done=%b grant=%b, required 1 1", got, bus_grant_cpu);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_n - n0 != 5 || bad_strobe != b0) begin
      n_fail++;
      $display("FAIL mid_reload_count: writes=%0d bad strobes=%0d, required 5 0", wr_n - n0, bad_strobe - b0);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (wr_addr[n0+i] !== AW'(13'h0040 + i) || wr_data[n0+i] !== src[i]) begin
        n_fail++;
        $display("FAIL mid_reload_write[%0d]: addr=%h data=%h, required %h %h", i, wr_addr[n0+i], wr_data[n0+i], AW'(13'h0040 + i), src[i]);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (viol_n != 0) begin
      n_fail++;
      $display("FAIL bus_invariants: %0d violating cycles, required 0", viol_n);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
